// File: rtl/hcu_round_scheduler_if.sv
// Handshake and control bundle between the HCU round scheduler and its
// block source / result consumer / round datapath.
interface hcu_round_scheduler_if #(
    parameter int IDX_WIDTH = 7
);
    logic                 start_valid;
    logic                 start_ready;
    logic                 mode_in;
    logic                 first_block;
    logic                 abort;
    logic                 data_width_flag;
    logic                 busy;
    logic                 hash_init_en;
    logic                 state_init_en;
    logic                 round_en;
    logic [IDX_WIDTH-1:0] round_idx;
    logic                 w_sel_msg;
    logic                 w_shift_en;
    logic                 hash_update_en;
    logic                 done_valid;
    logic                 done_ready;

    // Block source, result consumer and datapath side.
    modport master (
        output start_valid, mode_in, first_block, abort, done_ready,
        input  start_ready, data_width_flag, busy, hash_init_en, state_init_en,
               round_en, round_idx, w_sel_msg, w_shift_en, hash_update_en,
               done_valid
    );

    // Scheduler side.
    modport slave (
        input  start_valid, mode_in, first_block, abort, done_ready,
        output start_ready, data_width_flag, busy, hash_init_en, state_init_en,
               round_en, round_idx, w_sel_msg, w_shift_en, hash_update_en,
               done_valid
    );
endinterface

// File: rtl/hcu_round_scheduler.sv
// Round sequencer for one SHA-256/SHA-512 hash compression unit:
// IDLE -> INIT -> ROUND x N -> FINAL -> DONE, with abort and result handshake.
module hcu_round_scheduler #(
    parameter int ROUNDS_256 = 64,
    parameter int ROUNDS_512 = 80,
    parameter int MSG_WORDS  = 16,
    parameter int IDX_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    hcu_round_scheduler_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_ROUND = 3'd2;
    localparam logic [2:0] S_FINAL = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IDX_WIDTH-1:0] LAST_256 = IDX_WIDTH'(ROUNDS_256 - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_512 = IDX_WIDTH'(ROUNDS_512 - 1);
    localparam logic [IDX_WIDTH-1:0] MSG_LIM  = IDX_WIDTH'(MSG_WORDS);

    logic [2:0]           state_q, state_d;
    logic [IDX_WIDTH-1:0] round_idx_q, round_idx_d;
    logic                 mode_q, mode_d;
    logic                 first_q, first_d;
    logic [IDX_WIDTH-1:0] last_idx;

    assign last_idx = mode_q ? LAST_512 : LAST_256;

    always_comb begin
        state_d     = state_q;
        round_idx_d = round_idx_q;
        mode_d      = mode_q;
        first_d     = first_q;
        case (state_q)
            S_IDLE: begin
                // abort is irrelevant here, so a coincident start still goes through
                if (bus.start_valid) begin
                    state_d     = S_INIT;
                    mode_d      = bus.mode_in;
                    first_d     = bus.first_block;
                    round_idx_d = '0;
                end
            end
            S_INIT: begin
                state_d = bus.abort ? S_IDLE : S_ROUND;
            end
            S_ROUND: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (round_idx_q == last_idx) begin
                    state_d = S_FINAL;
                end else begin
                    round_idx_d = round_idx_q + 1'b1;
                end
            end
            S_FINAL: begin
                // The update strobe of this cycle still commits even when aborted.
                state_d = bus.abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                if (bus.done_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            round_idx_q <= '0;
            mode_q      <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_idx_q <= round_idx_d;
            mode_q      <= mode_d;
            first_q     <= first_d;
        end
    end

    assign bus.start_ready     = (state_q == S_IDLE);
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.data_width_flag = mode_q;
    assign bus.state_init_en   = (state_q == S_INIT);
    assign bus.hash_init_en    = (state_q == S_INIT) && first_q;
    assign bus.round_en        = (state_q == S_ROUND);
    assign bus.w_shift_en      = (state_q == S_ROUND);
    assign bus.w_sel_msg       = (state_q == S_ROUND) && (round_idx_q < MSG_LIM);
    assign bus.round_idx       = round_idx_q;
    assign bus.hash_update_en  = (state_q == S_FINAL);
    assign bus.done_valid      = (state_q == S_DONE);
endmodule

// File: tb/tb_hcu_round_scheduler.sv
// Directed bench for hcu_round_scheduler: table of whole-block runs plus
// hand-written backpressure, abort and reset sequences.
module tb_hcu_round_scheduler;
    localparam int IDX_WIDTH = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hcu_round_scheduler_if #(.IDX_WIDTH(IDX_WIDTH)) bus ();

    hcu_round_scheduler #(
        .ROUNDS_256 (64),
        .ROUNDS_512 (80),
        .MSG_WORDS  (16),
        .IDX_WIDTH  (IDX_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic mode;
        logic first;
        int   rounds;
        int   latency;
        int   hinit_cnt;
    } blk_vec_t;

    blk_vec_t vecs[4];

    // {start_ready, busy, flag, hinit, sinit, round_en, w_sel, w_shift, h_upd, done_valid, round_idx}
    localparam logic [16:0] RESET_VEC = {1'b1, 16'b0};

    function automatic logic [16:0] out_vec();
        return {bus.start_ready, bus.busy, bus.data_width_flag, bus.hash_init_en,
                bus.state_init_en, bus.round_en, bus.w_sel_msg, bus.w_shift_en,
                bus.hash_update_en, bus.done_valid, bus.round_idx};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Runs one block with done_ready tied high and checks every cycle of it.
    task automatic run_block(input blk_vec_t v, input int k);
        int rounds, sinit, hinit, hupd, done_at;
        int idx_bad, wsel_bad, flag_bad, both_bad;
        rounds = 0; sinit = 0; hinit = 0; hupd = 0; done_at = -1;
        idx_bad = 0; wsel_bad = 0; flag_bad = 0; both_bad = 0;
        bus.start_valid = 1'b1;
        bus.mode_in     = v.mode;
        bus.first_block = v.first;
        bus.done_ready  = 1'b1;
        check($sformatf("blk%0d start_ready", k), bus.start_ready, 1);
        for (int cyc = 1; cyc <= 200 && done_at < 0; cyc++) begin
            @(negedge clk);
            bus.start_valid = 1'b0;
            if (bus.state_init_en) begin
                sinit++;
                if (cyc != 1 || bus.round_idx != 0) idx_bad++;
            end
            if (bus.hash_init_en) hinit++;
            if (bus.round_en && bus.round_idx != IDX_WIDTH'(rounds)) idx_bad++;
            if (bus.w_sel_msg !== (bus.round_en && rounds < 16)) wsel_bad++;
            if (bus.w_shift_en !== bus.round_en) wsel_bad++;
            if (bus.round_en) rounds++;
            if (bus.hash_update_en) hupd++;
            if (bus.hash_update_en && bus.hash_init_en) both_bad++;
            if (bus.data_width_flag !== v.mode || bus.busy !== 1'b1) flag_bad++;
            if (bus.done_valid) done_at = cyc;
        end
        check($sformatf("blk%0d rounds", k), rounds, v.rounds);
        check($sformatf("blk%0d state_init count", k), sinit, 1);
        check($sformatf("blk%0d hash_init count", k), hinit, v.hinit_cnt);
        check($sformatf("blk%0d hash_update count", k), hupd, 1);
        check($sformatf("blk%0d done latency", k), done_at, v.latency);
        check($sformatf("blk%0d round_idx errors", k), idx_bad, 0);
        check($sformatf("blk%0d w_sel/w_shift errors", k), wsel_bad, 0);
        check($sformatf("blk%0d flag/busy errors", k), flag_bad, 0);
        check($sformatf("blk%0d init+update overlap", k), both_bad, 0);
        @(negedge clk);
        check($sformatf("blk%0d idle done_valid", k), bus.done_valid, 0);
        check($sformatf("blk%0d idle start_ready", k), bus.start_ready, 1);
        check($sformatf("blk%0d held round_idx", k), bus.round_idx, v.rounds - 1);
        check($sformatf("blk%0d held flag", k), bus.data_width_flag, v.mode);
    endtask

    // Steps until done_valid is seen, then takes it with done_ready high.
    task automatic finish_block(input string name);
        int found;
        found = 0;
        bus.done_ready = 1'b1;
        for (int i = 0; i < 120 && found == 0; i++) begin
            @(negedge clk);
            if (bus.done_valid) found = 1;
        end
        check({name, " done seen"}, found, 1);
        @(negedge clk);
    endtask

    initial begin
        int found, bad, cnt_upd, cnt_done, sinit;

        rst = 1'b1;
        bus.start_valid = 1'b0;
        bus.mode_in     = 1'b0;
        bus.first_block = 1'b0;
        bus.abort       = 1'b0;
        bus.done_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", out_vec(), RESET_VEC);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset idle", out_vec(), RESET_VEC);

        vecs[0] = '{mode: 1'b0, first: 1'b1, rounds: 64, latency: 67, hinit_cnt: 1};
        vecs[1] = '{mode: 1'b1, first: 1'b0, rounds: 80, latency: 83, hinit_cnt: 0};
        vecs[2] = '{mode: 1'b0, first: 1'b0, rounds: 64, latency: 67, hinit_cnt: 0};
        vecs[3] = '{mode: 1'b1, first: 1'b1, rounds: 80, latency: 83, hinit_cnt: 1};
        for (int k = 0; k < 4; k++) run_block(vecs[k], k);

        // Backpressure: done_ready low for 10 cycles, start_valid held high.
        bus.start_valid = 1'b1; bus.mode_in = 1'b0; bus.first_block = 1'b1;
        bus.done_ready = 1'b0;
        found = 0; sinit = 0;
        for (int i = 0; i < 120 && found == 0; i++) begin
            @(negedge clk);
            if (bus.state_init_en) sinit++;
            if (bus.done_valid) found = 1;
        end
        check("bp done seen", found, 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done_valid !== 1'b1 || bus.start_ready !== 1'b0) bad++;
            if (bus.state_init_en) sinit++;
            if (i < 9) @(negedge clk);
        end
        check("bp hold errors", bad, 0);
        check("bp single init", sinit, 1);
        bus.done_ready = 1'b1;
        @(negedge clk);
        check("bp idle start_ready", bus.start_ready, 1);
        check("bp idle done_valid", bus.done_valid, 0);
        @(negedge clk);
        check("bp re-accept init", bus.state_init_en, 1);
        bus.start_valid = 1'b0;
        finish_block("bp second");

        // Abort at round 30.
        bus.start_valid = 1'b1; bus.mode_in = 1'b0; bus.first_block = 1'b0;
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            @(negedge clk);
            bus.start_valid = 1'b0;
            if (bus.round_en && bus.round_idx == 30) found = 1;
        end
        check("abort reach idx30", found, 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort -> idle", {bus.busy, bus.start_ready, bus.round_en}, 3'b010);
        cnt_upd = 0; cnt_done = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.hash_update_en) cnt_upd++;
            if (bus.done_valid) cnt_done++;
            @(negedge clk);
        end
        check("abort no hash_update", cnt_upd, 0);
        check("abort no done_valid", cnt_done, 0);
        run_block(vecs[0], 4);

        // Abort coincident with FINAL.
        bus.start_valid = 1'b1; bus.mode_in = 1'b1; bus.first_block = 1'b1;
        found = 0;
        for (int i = 0; i < 120 && found == 0; i++) begin
            @(negedge clk);
            bus.start_valid = 1'b0;
            if (bus.hash_update_en) found = 1;
        end
        check("final-abort reach FINAL", found, 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("final-abort -> idle", {bus.busy, bus.start_ready, bus.hash_update_en}, 3'b010);
        cnt_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done_valid) cnt_done++;
            @(negedge clk);
        end
        check("final-abort no done_valid", cnt_done, 0);

        // start_valid with abort in IDLE accepts; abort in DONE is ignored.
        bus.start_valid = 1'b1; bus.abort = 1'b1; bus.mode_in = 1'b1; bus.first_block = 1'b0;
        bus.done_ready = 1'b0;
        @(negedge clk);
        bus.start_valid = 1'b0; bus.abort = 1'b0;
        check("start+abort accepted", {bus.state_init_en, bus.data_width_flag}, 2'b11);
        found = 0;
        for (int i = 0; i < 120 && found == 0; i++) begin
            @(negedge clk);
            if (bus.done_valid) found = 1;
        end
        check("done-abort done seen", found, 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort in DONE ignored", bus.done_valid, 1);
        bus.done_ready = 1'b1;
        @(negedge clk);
        check("done taken", {bus.done_valid, bus.start_ready}, 2'b01);

        // Reset at round 50 of a SHA-512 block.
        bus.start_valid = 1'b1; bus.mode_in = 1'b1; bus.first_block = 1'b1;
        found = 0;
        for (int i = 0; i < 80 && found == 0; i++) begin
            @(negedge clk);
            bus.start_valid = 1'b0;
            if (bus.round_en && bus.round_idx == 50) found = 1;
        end
        check("rst reach idx50", found, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid-round reset outputs", out_vec(), RESET_VEC);
        rst = 1'b0;
        @(negedge clk);
        check("after reset idle", out_vec(), RESET_VEC);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/hcu_round_scheduler.md
Name: hcu_round_scheduler

Overview:
- Sequencer for one hash compression unit (HCU).
- Accepts a start request per message block and selects SHA-256 (32-bit) or SHA-512 (64-bit) mode.
- Steps the round datapath through 64 or 80 rounds, including the Sigma/sigma units, K ROM and message schedule, then commits the hash update and handshakes completion.
- Drives data_width_flag to every Sigma instance in the HCU.

Parameters:
- ROUNDS_256, 64, round count in 32-bit mode.
- ROUNDS_512, 80, round count in 64-bit mode.
- MSG_WORDS, 16, rounds that take W_t directly from the message block.
- IDX_WIDTH, 7, width of round_idx; must hold ROUNDS_512-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start_valid  in  1  block ready to hash.
- start_ready  out  1  scheduler can accept a block.
- mode_in  in  1  0 = SHA-256, 1 = SHA-512; sampled on accept.
- first_block  in  1  1 = load IV into H registers; sampled on accept.
- abort  in  1  cancel the current block.
- data_width_flag  out  1  latched mode, fed to the Sigma/sigma units.
- busy  out  1  high in any state except IDLE.
- hash_init_en  out  1  load IV into H.
- state_init_en  out  1  load a..h from H.
- round_en  out  1  advance the a..h round registers.
- round_idx  out  IDX_WIDTH  current round t; also the K ROM address.
- w_sel_msg  out  1  1 = W_t from the message word, 0 = from the schedule recurrence.
- w_shift_en  out  1  shift the 16-entry W window.
- hash_update_en  out  1  H += a..h.
- done_valid  out  1  block result available.
- done_ready  in  1  consumer takes the result.

Behaviour:
- Reset values:
  - State = IDLE.
  - start_ready = 1.
  - All other outputs = 0, including data_width_flag, round_idx, busy and done_valid.
- Accept: start_valid && start_ready at a clk edge.
  - Latch mode_in into data_width_flag and first_block into an internal register.
  - N = ROUNDS_512 if mode = 1, else ROUNDS_256.
- FSM states:
  - IDLE:
    - start_ready = 1.
    - On accept -> INIT.
  - INIT (1 cycle):
    - state_init_en = 1.
    - hash_init_en = latched first_block.
    - round_idx = 0.
    - -> ROUND.
  - ROUND (N cycles):
    - round_en = 1 and w_shift_en = 1.
    - round_idx counts 0..N-1.
    - w_sel_msg = (round_idx < MSG_WORDS).
    - When round_idx == N-1 -> FINAL.
  - FINAL (1 cycle):
    - hash_update_en = 1.
    - -> DONE.
  - DONE:
    - done_valid = 1, held until done_ready is sampled high.
    - Then -> IDLE with done_valid = 0.
    - done_valid is never withdrawn before it is taken.
- Latency:
  - Accept edge in cycle c; INIT occupies cycle c+1.
  - done_valid first high in cycle c+N+3: c+67 for SHA-256, c+83 for SHA-512.
  - Minimum start-to-start interval is N+4 cycles when done_ready is tied high.
- Output rules:
  - start_ready = 1 only in IDLE; there is no accept in the DONE cycle.
  - data_width_flag is stable from INIT through DONE. It keeps its last value in IDLE and changes only on accept.
  - round_idx holds its last value (N-1) after ROUND and returns to 0 in INIT.
  - Strobes (hash_init_en, state_init_en, round_en, w_shift_en, hash_update_en) are exactly as listed per state and 0 elsewhere.
  - hash_update_en and hash_init_en are never high in the same cycle.
- Abort:
  - abort high in INIT, ROUND or FINAL -> IDLE on the next edge.
  - All strobes are 0 from that next cycle; hash_update_en does not fire after the abort edge; done_valid is not raised.
  - If abort and the FINAL cycle coincide, the hash update in that cycle still commits, no done_valid follows, and the next state is IDLE.
  - abort in IDLE or DONE is ignored.
- rst overrides everything, mid-block included: next cycle all outputs are at their reset values.
- Simultaneous start_valid and abort in IDLE: the accept proceeds and abort is ignored.

Test Plan:
- SHA-256 block:
  - Stimulus: mode_in = 0, first_block = 1, done_ready = 1.
  - Required: hash_init_en and state_init_en high one cycle; round_en high for exactly 64 cycles with round_idx 0..63; w_sel_msg high for idx 0..15 only; hash_update_en once; done_valid at accept+67; data_width_flag = 0 throughout.
- SHA-512 block:
  - Stimulus: mode_in = 1, first_block = 0.
  - Required: 80 rounds, round_idx reaches 79; hash_init_en never asserted; done_valid at accept+83; data_width_flag = 1 from INIT.
- Backpressure:
  - Stimulus: done_ready low for 10 cycles after done_valid rises; start_valid held high.
  - Required: done_valid stays high, start_ready = 0 the whole time, no second INIT; IDLE and accept only after done_ready.
- Abort:
  - Stimulus: abort at round_idx = 30.
  - Required: next cycle state IDLE; round_en = 0; no hash_update_en; no done_valid; next block runs normally.
- Abort in FINAL:
  - Stimulus: abort coincident with the FINAL cycle.
  - Required: hash_update_en high that cycle; done_valid never raised; state IDLE next cycle.
- Reset mid-round:
  - Stimulus: rst at round_idx = 50 (SHA-512).
  - Required: all outputs 0 and start_ready = 1 the next cycle; data_width_flag = 0.
